// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: sequences one multiply/divide op from issue to the mult/div unit through writeback.
// Define MULTDIV_DIVZERO_BYPASS_EN to resolve divide-by-zero requests without issuing them.

typedef enum logic [1:0] {
   MD_OP_MULL = 2'd0,
   MD_OP_MULH = 2'd1,
   MD_OP_DIV  = 2'd2,
   MD_OP_REM  = 2'd3
} sel_md_op_e;

module ibex_multdiv_issue (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  sel_md_op_e  req_op_i,
   input  logic [1:0]  req_signed_mode_i,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   input  logic [4:0]  req_rd_i,
   input  logic        flush_i,
   output logic        mult_en_o,
   output logic        div_en_o,
   output logic        mult_sel_o,
   output logic        div_sel_o,
   output sel_md_op_e  operator_o,
   output logic [1:0]  signed_mode_o,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   output logic        multdiv_ready_id_o,
   input  logic        multdiv_valid_i,
   input  logic [31:0] multdiv_result_i,
   input  logic [33:0] imd_val_d_i [2],
   input  logic [1:0]  imd_val_we_i,
   output logic [33:0] imd_val_q_o [2],
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, WB} state_e;

   state_e      state_q, state_d;
   logic        accept;
   logic        divzero;
   logic [31:0] dz_result;

   // flush_i masks acceptance so a request never slips in alongside a discard
   assign req_ready_o = !flush_i && ((state_q == IDLE) || (state_q == WB && wb_ready_i));
   assign accept      = req_valid_i && req_ready_o;

`ifdef MULTDIV_DIVZERO_BYPASS_EN
   assign divzero   = ((req_op_i == MD_OP_DIV) || (req_op_i == MD_OP_REM)) && (req_op_b_i == 32'h0);
   assign dz_result = (req_op_i == MD_OP_DIV) ? 32'hFFFF_FFFF : req_op_a_i;
`else
   assign divzero   = 1'b0;
   assign dz_result = 32'h0;
`endif

   always_comb begin
      state_d            = state_q;
      mult_en_o          = 1'b0;
      div_en_o           = 1'b0;
      multdiv_ready_id_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = divzero ? WB : RUN;
         end
         RUN: begin
            if (multdiv_valid_i) state_d = flush_i ? IDLE : WB;
            else if (flush_i)    state_d = DRAIN;
         end
         DRAIN: begin
            if (multdiv_valid_i) state_d = IDLE;
         end
         WB: begin
            if (flush_i)         state_d = IDLE;
            else if (wb_ready_i) state_d = accept ? (divzero ? WB : RUN) : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // DRAIN keeps the unit enabled so its internal FSM completes the abandoned op
      if (state_q == RUN || state_q == DRAIN) begin
         multdiv_ready_id_o = 1'b1;
         if (operator_o == MD_OP_MULL || operator_o == MD_OP_MULH) mult_en_o = 1'b1;
         else                                                      div_en_o  = 1'b1;
      end
   end

   assign mult_sel_o = mult_en_o;
   assign div_sel_o  = div_en_o;
   assign wb_valid_o = (state_q == WB);
   assign busy_o     = (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         operator_o    <= MD_OP_MULL;
         signed_mode_o <= 2'b00;
         op_a_o        <= 32'h0;
         op_b_o        <= 32'h0;
         wb_rd_o       <= 5'h0;
         wb_data_o     <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            operator_o    <= req_op_i;
            signed_mode_o <= req_signed_mode_i;
            op_a_o        <= req_op_a_i;
            op_b_o        <= req_op_b_i;
            wb_rd_o       <= req_rd_i;
         end
         if (accept && divzero)
            wb_data_o <= dz_result;
         else if (state_q == RUN && multdiv_valid_i && !flush_i)
            wb_data_o <= multdiv_result_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_val_q_o[0] <= 34'h0;
         imd_val_q_o[1] <= 34'h0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (imd_val_we_i[k]) imd_val_q_o[k] <= imd_val_d_i[k];
         end
      end
   end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: directed scenarios plus randomized traffic against a
// transaction-level scoreboard and a latency-programmable model of the mult/div unit.

module tb_ibex_multdiv_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready;
   sel_md_op_e  req_op;
   logic [1:0]  req_sm;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_rd;
   logic        flush;
   logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
   sel_md_op_e  operator_o;
   logic [1:0]  signed_mode_o;
   logic [31:0] op_a_o, op_b_o;
   logic        multdiv_ready_id_o;
   logic        mv;
   logic [31:0] mres;
   logic [33:0] imd_d [2];
   logic [1:0]  imd_we;
   logic [33:0] imd_q [2];
   logic        wb_valid_o, wb_ready;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ibex_multdiv_issue dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_signed_mode_i(req_sm), .req_op_a_i(req_a), .req_op_b_i(req_b), .req_rd_i(req_rd),
      .flush_i(flush),
      .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
      .operator_o(operator_o), .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
      .multdiv_ready_id_o(multdiv_ready_id_o), .multdiv_valid_i(mv), .multdiv_result_i(mres),
      .imd_val_d_i(imd_d), .imd_val_we_i(imd_we), .imd_val_q_o(imd_q),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .busy_o(busy_o)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural result of a RISC-V M-extension op, divide-by-zero and overflow included.
   function automatic logic [31:0] ref_result(input sel_md_op_e op, input logic [1:0] sm,
                                              input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] prod;
      sa   = sm[0] ? longint'($signed(a)) : longint'({32'h0, a});
      sb   = sm[1] ? longint'($signed(b)) : longint'({32'h0, b});
      prod = sa * sb;
      case (op)
         MD_OP_MULL: return prod[31:0];
         MD_OP_MULH: return prod[63:32];
         default: begin
            if (b == 32'h0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
            if (sm[0]) begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
            end else begin
               sa = longint'({32'h0, a});
               sb = longint'({32'h0, b});
            end
            return (op == MD_OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
         end
      endcase
   endfunction

   // Mult/div unit model: answers after lat enabled cycles with the architectural result.
   int lat = 4;
   bit rand_lat = 1'b0;
   int rsp_cnt = 0;
   int cur_lat = 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         rsp_cnt = 0;
         mv = 1'b0;
      end else if (mult_en_o || div_en_o) begin
         if (rsp_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 6)) : lat;
         rsp_cnt++;
         if (rsp_cnt >= cur_lat) begin
            mv      = 1'b1;
            mres    = ref_result(operator_o, signed_mode_o, op_a_o, op_b_o);
            rsp_cnt = 0;
         end else begin
            mv = 1'b0;
         end
      end else begin
         rsp_cnt = 0;
         mv = 1'b0;
      end
   end

   // Scoreboard: at most one accepted, un-retired, un-flushed request is outstanding.
   bit          pend = 1'b0;
   sel_md_op_e  p_op;
   logic [31:0] p_a, p_b, p_data;
   logic [4:0]  p_rd;
   int          age = 0;
   int          hs_cnt = 0;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         pend = 1'b0;
         age  = 0;
      end else begin
         chk_eq("mon_mult_sel", mult_sel_o, mult_en_o);
         chk_eq("mon_div_sel", div_sel_o, div_en_o);
         if (wb_valid_o) begin
            chk_eq("mon_wb_without_request", pend, 1'b1);
            chk_eq("mon_wb_enables", {mult_en_o, div_en_o, multdiv_ready_id_o}, 3'b000);
         end
         if (wb_valid_o && wb_ready && !flush && pend) begin
            chk_eq("mon_wb_rd", wb_rd_o, p_rd);
            chk_eq("mon_wb_data", wb_data_o, p_data);
            pend = 1'b0;
            hs_cnt++;
         end
         if (flush) begin
            chk_eq("mon_ready_under_flush", req_ready, 1'b0);
            pend = 1'b0;
         end
         if (!busy_o) begin
            chk_eq("mon_idle_enables", {mult_en_o, div_en_o, multdiv_ready_id_o}, 3'b000);
            if (!flush) chk_eq("mon_idle_ready", req_ready, 1'b1);
         end
         if (pend && (mult_en_o || div_en_o)) begin
            chk_eq("mon_operator", operator_o, p_op);
            chk_eq("mon_op_a", op_a_o, p_a);
            chk_eq("mon_op_b", op_b_o, p_b);
            chk_eq("mon_mult_en", mult_en_o, (p_op == MD_OP_MULL || p_op == MD_OP_MULH));
            chk_eq("mon_ready_id", multdiv_ready_id_o, 1'b1);
         end
         if (req_valid && req_ready) begin
            chk_eq("mon_accept_while_outstanding", pend, 1'b0);
            pend   = 1'b1;
            p_op   = req_op;
            p_a    = req_a;
            p_b    = req_b;
            p_rd   = req_rd;
            p_data = ref_result(req_op, req_sm, req_a, req_b);
            age    = 0;
         end else if (pend) begin
            age++;
            if (age == 100) chk_eq("mon_request_stalled", age, 0);
         end
      end
   end

   task automatic issue(input sel_md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_sm    = sm;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
   endtask

   // Returns one time unit after a negedge where wb_valid_o is high, or flags a timeout.
   task automatic wait_wb(input string tag);
      int n = 0;
      #1;
      while (!wb_valid_o && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!wb_valid_o) chk_eq({tag, "_timeout"}, wb_valid_o, 1'b1);
   endtask

   initial begin
      int en_cnt;
      int wb_cnt;
      req_valid = 1'b0;
      req_op    = MD_OP_MULL;
      req_sm    = 2'b00;
      req_a     = 32'h0;
      req_b     = 32'h0;
      req_rd    = 5'h0;
      flush     = 1'b0;
      wb_ready  = 1'b1;
      imd_d[0]  = 34'h0;
      imd_d[1]  = 34'h0;
      imd_we    = 2'b00;

      repeat (3) @(negedge clk);
      #1;
      chk_eq("rst_busy", busy_o, 1'b0);
      chk_eq("rst_wb_valid", wb_valid_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_eq("rst_ready", req_ready, 1'b1);
      chk_eq("rst_enables", {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o}, 5'h0);
      chk_eq("rst_operands", {op_a_o, op_b_o}, 64'h0);
      chk_eq("rst_wb", {wb_rd_o, wb_data_o}, 37'h0);
      chk_eq("rst_imd0", imd_q[0], 34'h0);
      chk_eq("rst_imd1", imd_q[1], 34'h0);

      // intermediate-value registers: independent per-lane write enables
      @(negedge clk);
      imd_d[0] = 34'h3_0000_0001;
      imd_d[1] = 34'h2_AAAA_5555;
      imd_we   = 2'b01;
      @(negedge clk);
      imd_we = 2'b00;
      #1;
      chk_eq("imd0_load", imd_q[0], 34'h3_0000_0001);
      chk_eq("imd1_hold", imd_q[1], 34'h0);
      @(negedge clk);
      imd_we = 2'b10;
      @(negedge clk);
      imd_we = 2'b00;
      #1;
      chk_eq("imd1_load", imd_q[1], 34'h2_AAAA_5555);
      chk_eq("imd0_hold", imd_q[0], 34'h3_0000_0001);

      // MULL 7x6, unit answers on the 4th RUN cycle
      @(negedge clk);
      lat = 4;
      wb_ready = 1'b1;
      issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5);
      #1;
      chk_eq("mull_accept_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      en_cnt = 0;
      wb_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (i == 0) chk_eq("mull_run_sel", {mult_sel_o, multdiv_ready_id_o, div_en_o}, 3'b110);
         if (mult_en_o) en_cnt++;
         if (wb_valid_o) begin
            wb_cnt++;
            chk_eq("mull_wb_data", wb_data_o, 32'h0000_002A);
            chk_eq("mull_wb_rd", wb_rd_o, 5'd5);
         end
         @(negedge clk);
      end
      chk_eq("mull_run_cycles", en_cnt, 4);
      chk_eq("mull_wb_count", wb_cnt, 1);

      // writeback back-pressure for 5 cycles
      lat = 2;
      wb_ready = 1'b0;
      issue(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 5'd9);
      @(negedge clk);
      req_valid = 1'b0;
      wait_wb("bp_wait");
      for (int i = 0; i < 5; i++) begin
         chk_eq("bp_wb_valid", wb_valid_o, 1'b1);
         chk_eq("bp_wb_data", wb_data_o, 32'd12);
         chk_eq("bp_wb_rd", wb_rd_o, 5'd9);
         chk_eq("bp_ready", req_ready, 1'b0);
         chk_eq("bp_enables", {mult_en_o, div_en_o, multdiv_ready_id_o}, 3'b000);
         @(negedge clk);
         #1;
      end
      wb_ready = 1'b1;
      #1;
      chk_eq("bp_ready_on_release", req_ready, 1'b1);
      @(negedge clk);
      #1;
      chk_eq("bp_wb_retired", wb_valid_o, 1'b0);

      // DIV 100/7 flushed on its 3rd RUN cycle
      @(negedge clk);
      lat = 8;
      issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd4);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk_eq("flush_div_en", {div_en_o, div_sel_o, mult_en_o}, 3'b110);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk_eq("flush_ready", req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      en_cnt = 0;
      wb_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (i == 0) chk_eq("drain_busy", busy_o, 1'b1);
         if (div_en_o) en_cnt++;
         if (wb_valid_o) wb_cnt++;
         @(negedge clk);
      end
      chk_eq("drain_div_en_cycles", en_cnt, 5);
      chk_eq("drain_no_wb", wb_cnt, 0);
      #1;
      chk_eq("drain_ready_after", req_ready, 1'b1);
      chk_eq("drain_idle", busy_o, 1'b0);

      // divide-by-zero
      @(negedge clk);
      lat = 3;
      issue(MD_OP_DIV, 2'b00, 32'd5, 32'd0, 5'd3);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
`ifdef MULTDIV_DIVZERO_BYPASS_EN
      chk_eq("dz_div_fast_wb", wb_valid_o, 1'b1);
      chk_eq("dz_div_no_en", div_en_o, 1'b0);
`else
      chk_eq("dz_div_issued", div_en_o, 1'b1);
`endif
      wait_wb("dz_div_wait");
      chk_eq("dz_div_data", wb_data_o, 32'hFFFF_FFFF);
      chk_eq("dz_div_rd", wb_rd_o, 5'd3);
      @(negedge clk);
      issue(MD_OP_REM, 2'b00, 32'd5, 32'd0, 5'd6);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
`ifdef MULTDIV_DIVZERO_BYPASS_EN
      chk_eq("dz_rem_fast_wb", wb_valid_o, 1'b1);
      chk_eq("dz_rem_no_en", div_en_o, 1'b0);
`else
      chk_eq("dz_rem_issued", div_en_o, 1'b1);
`endif
      wait_wb("dz_rem_wait");
      chk_eq("dz_rem_data", wb_data_o, 32'h0000_0005);

      // back-to-back: new request accepted in the writeback handshake cycle
      @(negedge clk);
      lat = 2;
      wb_ready = 1'b0;
      issue(MD_OP_MULL, 2'b00, 32'd2, 32'd3, 5'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_wb("b2b_first_wait");
      chk_eq("b2b_first_data", wb_data_o, 32'd6);
      wb_ready = 1'b1;
      issue(MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd7);
      #1;
      chk_eq("b2b_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk_eq("b2b_wb_dropped", wb_valid_o, 1'b0);
      chk_eq("b2b_reenable", {mult_en_o, busy_o}, 2'b11);
      chk_eq("b2b_operator", operator_o, MD_OP_MULH);
      wait_wb("b2b_second_wait");
      chk_eq("b2b_second_data", wb_data_o, 32'hFFFF_FFFF);
      chk_eq("b2b_second_rd", wb_rd_o, 5'd7);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      lat = 20;
      issue(MD_OP_DIV, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd2);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_eq("arst_pre_div_en", div_en_o, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_eq("arst_enables", {mult_en_o, div_en_o, multdiv_ready_id_o}, 3'b000);
      chk_eq("arst_busy_wb", {busy_o, wb_valid_o}, 2'b00);
      chk_eq("arst_operands", {op_a_o, op_b_o}, 64'h0);
      chk_eq("arst_wb", {wb_rd_o, wb_data_o}, 37'h0);
      chk_eq("arst_imd0", imd_q[0], 34'h0);
      chk_eq("arst_imd1", imd_q[1], 34'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_eq("arst_ready_after", req_ready, 1'b1);
      chk_eq("arst_idle_after", busy_o, 1'b0);

      // randomized traffic, scored by the monitor
      rand_lat = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 9) < 7);
         req_op    = sel_md_op_e'($urandom_range(0, 3));
         req_sm    = 2'($urandom_range(0, 3));
         req_a     = $urandom;
         req_b     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         req_rd    = 5'($urandom_range(0, 31));
         flush     = ($urandom_range(0, 19) == 0);
         wb_ready  = ($urandom_range(0, 9) < 6);
      end
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      wb_ready  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (!busy_o && !pend) break;
         @(negedge clk);
      end
      chk_eq("end_idle", busy_o, 1'b0);
      chk_eq("end_nothing_outstanding", pend, 1'b0);
      chk_eq("end_traffic_retired", (hs_cnt > 100), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ibex_multdiv_issue.md
IBEX_MULTDIV_ISSUE -- requirements
Module: ibex_multdiv_issue

Interface
REQ-001 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset; one clock domain.
REQ-002 SHALL have upstream ports: req_valid_i in 1; req_ready_o out 1; req_op_i in sel_md_op_e; req_signed_mode_i in 2; req_op_a_i in 32; req_op_b_i in 32; req_rd_i in 5; flush_i in 1 (discard in-flight op).
REQ-003 SHALL have responder-side ports: mult_en_o, div_en_o, mult_sel_o, div_sel_o out 1 each; operator_o out sel_md_op_e; signed_mode_o out 2; op_a_o, op_b_o out 32; multdiv_ready_id_o out 1; multdiv_valid_i in 1; multdiv_result_i in 32.
REQ-004 SHALL have intermediate-register ports: imd_val_d_i in 2x34; imd_val_we_i in 2; imd_val_q_o out 2x34.
REQ-005 SHALL have writeback ports: wb_valid_o out 1; wb_ready_i in 1; wb_rd_o out 5; wb_data_o out 32; busy_o out 1 (state != IDLE).

Function
REQ-006 SHALL implement FSM IDLE, RUN, DRAIN, WB.
REQ-007 req_ready_o SHALL be 1 in IDLE, and in WB when wb_ready_i=1; 0 otherwise; forced 0 whenever flush_i=1.
REQ-008 On req_valid_i & req_ready_o at edge T: op, signed_mode, op_a, op_b, rd SHALL register; state RUN from T+1.
REQ-009 operator_o, signed_mode_o, op_a_o, op_b_o SHALL be registered copies, stable from acceptance until next acceptance.
REQ-010 In RUN and DRAIN: mult_en_o=mult_sel_o=1 for MULL/MULH; div_en_o=div_sel_o=1 for DIV/REM; multdiv_ready_id_o=1. In IDLE and WB all four enables and multdiv_ready_id_o SHALL be 0.
REQ-011 RUN & multdiv_valid_i: multdiv_result_i SHALL be captured into wb_data_o register; state WB next cycle; enables deassert that same next cycle.
REQ-012 WB: wb_valid_o=1, wb_data_o/wb_rd_o stable until wb_ready_i=1; then IDLE, or RUN if new request accepted in that cycle (back-to-back, no bubble).
REQ-013 RUN & flush_i & !multdiv_valid_i: SHALL go to DRAIN; DRAIN keeps enables asserted until multdiv_valid_i, discards result, goes IDLE; no wb_valid_o for flushed op.
REQ-014 RUN & flush_i & multdiv_valid_i same cycle: result discarded, IDLE next cycle.
REQ-015 WB & flush_i: wb_valid_o SHALL drop next cycle, state IDLE; flush_i beats wb_ready_i.
REQ-016 IDLE & flush_i & req_valid_i: request SHALL NOT be accepted.
REQ-017 imd_val_q_o[k] SHALL load imd_val_d_i[k] at edge where imd_val_we_i[k]=1, in any state; otherwise hold.
REQ-018 Exactly one wb_valid_o handshake SHALL occur per non-flushed accepted request.

Reset
REQ-019 On rst_ni=0 (asynchronous, any state incl. mid-RUN): state IDLE; captured operands, rd, wb_data 0; imd_val_q_o both 34'h0; all enables, wb_valid_o, busy_o 0; req_ready_o 1 after release.
REQ-020 Responder FSM shares rst_ni; no drain SHALL be required after reset.

Configuration
REQ-021 Macro MULTDIV_DIVZERO_BYPASS_EN SHALL control divide-by-zero fast path.
REQ-022 Defined: accepted DIV/REM with req_op_b_i==0 SHALL go IDLE->WB directly (wb_valid_o at T+1), wb_data_o=32'hFFFF_FFFF for DIV, req_op_a_i for REM; enables never asserted.
REQ-023 Undefined: such requests SHALL issue through RUN like any other op; result taken from multdiv_result_i.

Verification
REQ-024 MULL 7x6, signed 00, model responder valid after 4 RUN cycles -> single wb_valid_o, wb_data_o=0x0000_002A, wb_rd_o=req rd.
REQ-025 Result ready, wb_ready_i=0 for 5 cycles -> wb_valid_o, wb_data_o stable; req_ready_o=0; enables 0; handshake on 6th cycle.
REQ-026 DIV 100/7, flush_i pulse 3rd RUN cycle -> DRAIN, div_en_o held until multdiv_valid_i, no wb_valid_o, then IDLE, req_ready_o=1.
REQ-027 DIV 5/0 with macro -> wb_data_o=0xFFFF_FFFF at T+1, div_en_o never 1; REM 5/0 -> 0x0000_0005; without macro -> div_en_o asserted, result from responder.
REQ-028 imd_val_we_i=2'b01, imd_val_d_i[0]=34'h3_0000_0001 -> imd_val_q_o[0] updates next edge, [1] unchanged; rst_ni low mid-RUN -> all zero, IDLE.
REQ-029 WB with wb_ready_i=1 and req_valid_i=1 -> new request accepted same edge, RUN next cycle, enables reassert.
